// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered RV32I decode stage feeding the ALU.
// One pipeline register between fetch and execute, valid/ready handshake,
// synchronous flush, asynchronous active-low reset.
// Optional build macro: ALU_DECODE_ILLEGAL_CHK_EN adds illegal-encoding
// detection; when it is undefined illegal_w_o_h is tied low.
module alu_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_w_i,
  input  logic            rst_w_i_l,
  input  logic            flush_w_i_h,
  input  logic [31:0]     instr_w_i,
  input  logic [XLEN-1:0] pc_w_i,
  input  logic            in_valid_w_i_h,
  output logic            in_ready_w_o_h,
  output logic            out_valid_w_o_h,
  input  logic            out_ready_w_i_h,
  output logic [3:0]      alu_control_w_o,
  output logic            addi_sub_flag_w_o,
  output logic [XLEN-1:0] imm_w_o,
  output logic [XLEN-1:0] pc_w_o,
  output logic [4:0]      rs1_w_o,
  output logic [4:0]      rs2_w_o,
  output logic [4:0]      rd_w_o,
  output logic            a_sel_pc_w_o_h,
  output logic            b_sel_imm_w_o_h,
  output logic            reg_wr_w_o_h,
  output logic            illegal_w_o_h
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [6:0] opcode;
  logic [2:0] f3;

  assign opcode = instr_w_i[6:0];
  assign f3     = instr_w_i[14:12];

  // Immediate formats, all sign-extended from instr[31]
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{(XLEN-12){instr_w_i[31]}}, instr_w_i[31:20]};
  assign imm_s = {{(XLEN-12){instr_w_i[31]}}, instr_w_i[31:25], instr_w_i[11:7]};
  assign imm_b = {{(XLEN-13){instr_w_i[31]}}, instr_w_i[31], instr_w_i[7],
                  instr_w_i[30:25], instr_w_i[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){instr_w_i[31]}}, instr_w_i[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){instr_w_i[31]}}, instr_w_i[31], instr_w_i[19:12],
                  instr_w_i[20], instr_w_i[30:21], 1'b0};

  // Decoded bundle (combinational), captured into the stage register on load
  logic [3:0]      alu_next;
  logic            flag_next;
  logic [XLEN-1:0] imm_next;
  logic [4:0]      rs1_next;
  logic            a_sel_next;
  logic            b_sel_next;
  logic            wr_class;
  logic            reg_wr_next;
  logic            illegal_next;

`ifdef ALU_DECODE_ILLEGAL_CHK_EN
  logic [6:0] f7;
  logic       opcode_known;
  logic       f7_legal;
  logic       is_shift_imm;

  assign f7           = instr_w_i[31:25];
  assign opcode_known = opcode inside {OPC_OP, OPC_OP_IMM, OPC_BRANCH, OPC_LOAD,
                                       OPC_STORE, OPC_JALR, OPC_JAL, OPC_LUI,
                                       OPC_AUIPC};
  assign f7_legal     = (f7 == 7'b0000000) || (f7 == 7'b0100000);
  assign is_shift_imm = (opcode == OPC_OP_IMM) && ((f3 == 3'b001) || (f3 == 3'b101));

  // Encodings the ALU cannot execute
  always_comb begin
    illegal_next = 1'b0;
    if (!opcode_known)
      illegal_next = 1'b1;
    else if ((opcode == OPC_OP) && !f7_legal)
      illegal_next = 1'b1;
    else if ((opcode == OPC_OP) && (f7 == 7'b0100000) && (f3 != 3'b000) && (f3 != 3'b101))
      illegal_next = 1'b1;
    else if (is_shift_imm && !f7_legal)
      illegal_next = 1'b1;
  end
`else
  assign illegal_next = 1'b0;
`endif

  // Opcode decode into ALU controls, immediate and operand selects
  always_comb begin
    alu_next   = 4'b0000;
    flag_next  = 1'b0;
    imm_next   = '0;
    rs1_next   = instr_w_i[19:15];
    a_sel_next = 1'b0;
    b_sel_next = 1'b1;
    wr_class   = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_next   = {instr_w_i[30], f3};
        flag_next  = 1'b1;
        b_sel_next = 1'b0;
        wr_class   = 1'b1;
      end
      OPC_OP_IMM: begin
        // bit 30 is only an opcode bit for right shifts; elsewhere it is immediate
        alu_next = (f3 == 3'b101) ? {instr_w_i[30], f3} : {1'b0, f3};
        imm_next = imm_i;
        wr_class = 1'b1;
      end
      OPC_BRANCH: begin
        alu_next   = 4'b1000;
        flag_next  = 1'b1;
        b_sel_next = 1'b0;
        imm_next   = imm_b;
      end
      OPC_LOAD: begin
        imm_next = imm_i;
        wr_class = 1'b1;
      end
      OPC_STORE: begin
        imm_next = imm_s;
      end
      OPC_JALR: begin
        imm_next = imm_i;
        wr_class = 1'b1;
      end
      OPC_JAL: begin
        imm_next   = imm_j;
        a_sel_next = 1'b1;
        wr_class   = 1'b1;
      end
      OPC_LUI: begin
        imm_next = imm_u;
        rs1_next = 5'd0;
        wr_class = 1'b1;
      end
      OPC_AUIPC: begin
        imm_next   = imm_u;
        a_sel_next = 1'b1;
        wr_class   = 1'b1;
      end
      default: begin
        // unknown opcode: behaves as ADD with no register write
      end
    endcase
    if (illegal_next) begin
      alu_next  = 4'b0000;
      flag_next = 1'b0;
      wr_class  = 1'b0;
    end
  end

  assign reg_wr_next = wr_class && (instr_w_i[11:7] != 5'd0);

  // Stage register
  logic            valid_reg;
  logic [3:0]      alu_reg;
  logic            flag_reg;
  logic [XLEN-1:0] imm_reg;
  logic [XLEN-1:0] pc_reg;
  logic [4:0]      rs1_reg, rs2_reg, rd_reg;
  logic            a_sel_reg, b_sel_reg, reg_wr_reg, illegal_reg;
  logic            load;

  assign in_ready_w_o_h = !valid_reg || out_ready_w_i_h;
  assign load           = in_valid_w_i_h && in_ready_w_o_h;

  // Flush beats load; an accepted bundle without replacement empties the stage
  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      valid_reg   <= 1'b0;
      alu_reg     <= 4'b0000;
      flag_reg    <= 1'b0;
      imm_reg     <= '0;
      pc_reg      <= '0;
      rs1_reg     <= 5'd0;
      rs2_reg     <= 5'd0;
      rd_reg      <= 5'd0;
      a_sel_reg   <= 1'b0;
      b_sel_reg   <= 1'b0;
      reg_wr_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else if (flush_w_i_h) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg   <= 1'b1;
      alu_reg     <= alu_next;
      flag_reg    <= flag_next;
      imm_reg     <= imm_next;
      pc_reg      <= pc_w_i;
      rs1_reg     <= rs1_next;
      rs2_reg     <= instr_w_i[24:20];
      rd_reg      <= instr_w_i[11:7];
      a_sel_reg   <= a_sel_next;
      b_sel_reg   <= b_sel_next;
      reg_wr_reg  <= reg_wr_next;
      illegal_reg <= illegal_next;
    end else if (out_ready_w_i_h) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid_w_o_h   = valid_reg;
  assign alu_control_w_o   = alu_reg;
  assign addi_sub_flag_w_o = flag_reg;
  assign imm_w_o           = imm_reg;
  assign pc_w_o            = pc_reg;
  assign rs1_w_o           = rs1_reg;
  assign rs2_w_o           = rs2_reg;
  assign rd_w_o            = rd_reg;
  assign a_sel_pc_w_o_h    = a_sel_reg;
  assign b_sel_imm_w_o_h   = b_sel_reg;
  assign reg_wr_w_o_h      = reg_wr_reg;
`ifdef ALU_DECODE_ILLEGAL_CHK_EN
  assign illegal_w_o_h     = illegal_reg;
`else
  assign illegal_w_o_h     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Testbench for alu_decode_stage: table-driven decode vectors through a
// scoreboard queue, plus hand sequences for backpressure, flush and reset.
// Honours ALU_DECODE_ILLEGAL_CHK_EN when choosing illegal-case expectations.
module tb_alu_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_control;
  logic        addi_sub_flag;
  logic [31:0] imm;
  logic [31:0] pc_o;
  logic [4:0]  rs1, rs2, rd;
  logic        a_sel_pc, b_sel_imm, reg_wr, illegal;

  alu_decode_stage #(.XLEN(32)) dut (
    .clk_w_i          (clk),
    .rst_w_i_l        (rst_n),
    .flush_w_i_h      (flush),
    .instr_w_i        (instr),
    .pc_w_i           (pc),
    .in_valid_w_i_h   (in_valid),
    .in_ready_w_o_h   (in_ready),
    .out_valid_w_o_h  (out_valid),
    .out_ready_w_i_h  (out_ready),
    .alu_control_w_o  (alu_control),
    .addi_sub_flag_w_o(addi_sub_flag),
    .imm_w_o          (imm),
    .pc_w_o           (pc_o),
    .rs1_w_o          (rs1),
    .rs2_w_o          (rs2),
    .rd_w_o           (rd),
    .a_sel_pc_w_o_h   (a_sel_pc),
    .b_sel_imm_w_o_h  (b_sel_imm),
    .reg_wr_w_o_h     (reg_wr),
    .illegal_w_o_h    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_DECODE_ILLEGAL_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  alu;
    logic        flag;
    logic [31:0] imm;
    logic        imm_chk;
    logic [4:0]  rs1, rs2, rd;
    logic        a_sel, b_sel, reg_wr, illegal;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl [20];
  vec_t sb_q [$];
  bit   model_valid;

  function automatic vec_t mk(input logic [31:0] i, input logic [3:0] a, input logic f,
                              input logic [31:0] im, input logic ic,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                              input logic as, input logic bs, input logic w, input logic il);
    vec_t v;
    v.instr = i; v.pc = 32'h0; v.alu = a; v.flag = f; v.imm = im; v.imm_chk = ic;
    v.rs1 = r1; v.rs2 = r2; v.rd = d; v.a_sel = as; v.b_sel = bs; v.reg_wr = w; v.illegal = il;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_bundle(input vec_t e);
    string t;
    t = $sformatf("instr=%h", e.instr);
    chk({t, " alu_control"}, 32'(alu_control), 32'(e.alu));
    chk({t, " addi_sub_flag"}, 32'(addi_sub_flag), 32'(e.flag));
    if (e.imm_chk) chk({t, " imm"}, imm, e.imm);
    chk({t, " pc"}, pc_o, e.pc);
    chk({t, " rs1"}, 32'(rs1), 32'(e.rs1));
    chk({t, " rs2"}, 32'(rs2), 32'(e.rs2));
    chk({t, " rd"}, 32'(rd), 32'(e.rd));
    chk({t, " a_sel_pc"}, 32'(a_sel_pc), 32'(e.a_sel));
    chk({t, " b_sel_imm"}, 32'(b_sel_imm), 32'(e.b_sel));
    chk({t, " reg_wr"}, 32'(reg_wr), 32'(e.reg_wr));
    chk({t, " illegal"}, 32'(illegal), 32'(e.illegal));
  endtask

  // One clock cycle, entered and left on the falling edge.
  task automatic do_cycle(input vec_t v, input logic [31:0] v_pc, input logic vld,
                          input logic ordy, input logic fl);
    vec_t e;
    logic exp_ready;
    e = v;
    e.pc = v_pc;
    instr = v.instr; pc = v_pc; in_valid = vld; out_ready = ordy; flush = fl;
    #1;
    exp_ready = !model_valid || ordy;
    chk("out_valid", 32'(out_valid), 32'(model_valid));
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    if (model_valid) begin
      if (sb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL scoreboard: got valid bundle expected empty queue");
      end else begin
        chk_bundle(sb_q[0]);
        if (ordy) begin
          $display("xfer instr=%h pc=%h alu=%b imm=%h", sb_q[0].instr, sb_q[0].pc,
                   alu_control, imm);
          void'(sb_q.pop_front());
        end
      end
    end
    @(posedge clk);
    if (fl) begin
      model_valid = 1'b0;
      sb_q.delete();
    end else if (vld && exp_ready) begin
      sb_q.push_back(e);
      model_valid = 1'b1;
    end else if (ordy) begin
      model_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " alu_control"}, 32'(alu_control), 32'd0);
    chk({tag, " addi_sub_flag"}, 32'(addi_sub_flag), 32'd0);
    chk({tag, " imm"}, imm, 32'd0);
    chk({tag, " pc"}, pc_o, 32'd0);
    chk({tag, " rs1"}, 32'(rs1), 32'd0);
    chk({tag, " rs2"}, 32'(rs2), 32'd0);
    chk({tag, " rd"}, 32'(rd), 32'd0);
    chk({tag, " a_sel_pc"}, 32'(a_sel_pc), 32'd0);
    chk({tag, " b_sel_imm"}, 32'(b_sel_imm), 32'd0);
    chk({tag, " reg_wr"}, 32'(reg_wr), 32'd0);
    chk({tag, " illegal"}, 32'(illegal), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t idle;
    // instr, alu, flag, imm, imm_chk, rs1, rs2, rd, a_sel, b_sel, reg_wr, illegal
    tbl[0]  = mk(32'h002081B3, 4'b0000, 1, 32'h0,        0, 1, 2, 3,   0, 0, 1, 0); // add
    tbl[1]  = mk(32'h402081B3, 4'b1000, 1, 32'h0,        0, 1, 2, 3,   0, 0, 1, 0); // sub
    tbl[2]  = mk(32'h40335293, 4'b1101, 0, 32'h403,      1, 6, 3, 5,   0, 1, 1, 0); // srai
    tbl[3]  = mk(32'h4000C093, 4'b0100, 0, 32'h400,      1, 1, 0, 1,   0, 1, 1, 0); // xori
    tbl[4]  = mk(32'hFFF00093, 4'b0000, 0, 32'hFFFFFFFF, 1, 0, 31, 1,  0, 1, 1, 0); // addi -1
    tbl[5]  = mk(32'h00208463, 4'b1000, 1, 32'h8,        1, 1, 2, 8,   0, 0, 0, 0); // beq +8
    tbl[6]  = mk(32'hFE0008E3, 4'b1000, 1, 32'hFFFFFFF0, 1, 0, 0, 17,  0, 0, 0, 0); // beq -16
    tbl[7]  = mk(32'h0020A623, 4'b0000, 0, 32'd12,       1, 1, 2, 12,  0, 1, 0, 0); // sw
    tbl[8]  = mk(32'h123452B7, 4'b0000, 0, 32'h12345000, 1, 0, 3, 5,   0, 1, 1, 0); // lui
    tbl[9]  = mk(32'h80000017, 4'b0000, 0, 32'h80000000, 1, 0, 0, 0,   1, 1, 0, 0); // auipc x0
    tbl[10] = mk(32'hFFDFF0EF, 4'b0000, 0, 32'hFFFFFFFC, 1, 31, 29, 1, 1, 1, 1, 0); // jal -4
    tbl[11] = mk(32'h00008067, 4'b0000, 0, 32'h0,        1, 1, 0, 0,   0, 1, 0, 0); // jalr x0
    tbl[12] = mk(32'hFF812203, 4'b0000, 0, 32'hFFFFFFF8, 1, 2, 24, 4,  0, 1, 1, 0); // lw -8
    tbl[13] = mk(32'h0020F1B3, 4'b0111, 1, 32'h0,        0, 1, 2, 3,   0, 0, 1, 0); // and
    tbl[14] = CHK ? mk(32'h7E2081B3, 4'b0000, 0, 32'h0, 0, 1, 2, 3, 0, 0, 0, 1)
                  : mk(32'h7E2081B3, 4'b1000, 1, 32'h0, 0, 1, 2, 3, 0, 0, 1, 0);
    tbl[15] = mk(32'h000000FF, 4'b0000, 0, 32'h0, 0, 0, 0, 1, 0, 1, 0, CHK);        // unknown
    tbl[16] = CHK ? mk(32'h60335293, 4'b0000, 0, 32'h603, 1, 6, 3, 5, 0, 1, 0, 1)
                  : mk(32'h60335293, 4'b1101, 0, 32'h603, 1, 6, 3, 5, 0, 1, 1, 0);
    tbl[17] = CHK ? mk(32'h402091B3, 4'b0000, 0, 32'h0, 0, 1, 2, 3, 0, 0, 0, 1)
                  : mk(32'h402091B3, 4'b1001, 1, 32'h0, 0, 1, 2, 3, 0, 0, 1, 0);
    tbl[18] = mk(32'h00309093, 4'b0001, 0, 32'h3,        1, 1, 3, 1,   0, 1, 1, 0); // slli
    tbl[19] = mk(32'h40208033, 4'b1000, 1, 32'h0,        0, 1, 2, 0,   0, 0, 0, 0); // sub x0
    idle = mk(32'hDEADBEEF, 4'b0000, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);

    model_valid = 1'b0;
    rst_n = 1'b0; flush = 1'b0; instr = 32'h0; pc = 32'h0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back stream through the table at full throughput
    for (int i = 0; i < 20; i++)
      do_cycle(tbl[i], 32'h1000 + 32'(i) * 4, 1'b1, 1'b1, 1'b0);
    do_cycle(idle, 32'h0, 1'b0, 1'b1, 1'b0);

    // Backpressure: addi held for 3 cycles while add waits, then swaps in
    do_cycle(tbl[4], 32'h2000, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      do_cycle(tbl[0], 32'h2004, 1'b1, 1'b0, 1'b0);
    do_cycle(tbl[0], 32'h2004, 1'b1, 1'b1, 1'b0);
    do_cycle(idle, 32'h0, 1'b0, 1'b1, 1'b0);

    // Flush together with a valid input discards it
    do_cycle(tbl[3], 32'h3000, 1'b1, 1'b1, 1'b0);
    do_cycle(tbl[1], 32'h3004, 1'b1, 1'b1, 1'b1);
    do_cycle(idle, 32'h0, 1'b0, 1'b1, 1'b0);

    // Flush of a stalled bundle
    do_cycle(tbl[4], 32'h3100, 1'b1, 1'b1, 1'b0);
    do_cycle(idle, 32'h0, 1'b0, 1'b0, 1'b1);
    do_cycle(idle, 32'h0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset pulse between edges drops the held bundle
    do_cycle(tbl[0], 32'h4000, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    #1;
    rst_n = 1'b1;
    sb_q.delete();
    model_valid = 1'b0;
    @(negedge clk);
    do_cycle(idle, 32'h0, 1'b0, 1'b1, 1'b0);
    do_cycle(tbl[2], 32'h5000, 1'b1, 1'b1, 1'b0);
    do_cycle(idle, 32'h0, 1'b0, 1'b1, 1'b0);

    if (sb_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered RV32I decode stage that produces the control interface consumed by the ALU: converts a fetched instruction word into `alu_control`, `addi_sub_flag`, the immediate, register indices and operand selects. It sits between fetch and execute as a single pipeline register with a valid/ready handshake and synchronous flush.

## Interface
- `XLEN`, 32, datapath width. Only 32 is supported.
- `clk_w_i`  in  1  clock; all state updates on the rising edge.
- `rst_w_i_l`  in  1  reset; asynchronous, active-low.
- `flush_w_i_h`  in  1  synchronous flush of the stage register.
- `instr_w_i`  in  32  instruction word.
- `pc_w_i`  in  32  PC of `instr_w_i`.
- `in_valid_w_i_h`  in  1  upstream word valid.
- `in_ready_w_o_h`  out  1  stage can accept a word.
- `out_valid_w_o_h`  out  1  decoded bundle valid.
- `out_ready_w_i_h`  in  1  execute accepts the bundle.
- `alu_control_w_o`  out  4  ALU operation code.
- `addi_sub_flag_w_o`  out  1  selects SUB (1) or ADD (0) for code 4'b1000.
- `imm_w_o`  out  32  sign-extended immediate.
- `pc_w_o`  out  32  registered PC.
- `rs1_w_o`, `rs2_w_o`, `rd_w_o`  out  5 each  register indices.
- `a_sel_pc_w_o_h`  out  1  ALU A operand = PC (AUIPC, JAL).
- `b_sel_imm_w_o_h`  out  1  ALU B operand = immediate.
- `reg_wr_w_o_h`  out  1  instruction writes `rd` (forced 0 when `rd`=0).
- `illegal_w_o_h`  out  1  unsupported encoding.

## Operation
- Handshake: `in_ready_w_o_h = !out_valid_w_o_h || out_ready_w_i_h` (combinational).
- Load occurs when `in_valid_w_i_h && in_ready_w_o_h`. All outputs are registered and come from a single decoded bundle.
- Load with `out_ready_w_i_h` high and `out_valid_w_o_h` high replaces the bundle in the same cycle, giving full throughput.
- Without a load, `out_valid_w_o_h` clears when it is accepted (`out_ready_w_i_h` high). Otherwise it holds and the bundle is stable.
- Decode of ALU controls, where `f3` = instr[14:12]:
  - OP (0110011): `alu_control` = {instr[30], f3}, flag = 1.
  - OP-IMM (0010011), f3=101: `alu_control` = {instr[30], 101}, giving SRLI or SRAI.
  - OP-IMM, all other f3: `alu_control` = {0, f3}. Immediate bit 30 never leaks into the code. Flag = 0.
  - BRANCH: 4'b1000, flag = 1.
  - LOAD, STORE, JALR, JAL, LUI, AUIPC: 4'b0000, flag = 0. LUI has rs1 forced to 0.
- Immediates: I, S, B, U and J formats, sign-extended from instr[31].
- Operand selects:
  - `b_sel_imm_w_o_h` = 1 for all opcodes except OP and BRANCH.
  - `a_sel_pc_w_o_h` = 1 for AUIPC and JAL.
- `reg_wr_w_o_h` = 1 for OP, OP-IMM, LOAD, JAL, JALR, LUI and AUIPC, gated by `rd` != 0.

## Timing
- Latency: 1 cycle from input acceptance to `out_valid_w_o_h`.
- Reset (async assert, sync-safe deassert): `out_valid_w_o_h`=0 and all other outputs 0. `in_ready_w_o_h` is therefore 1.
- Flush: `out_valid_w_o_h` is 0 on the next edge and any simultaneous load is discarded. Flush has priority over load. Bundle fields may hold stale data.
- Reset mid-handshake drops the held bundle. There is no replay.
- `rst_w_i_l` low overrides flush and load.

## Configuration
- `ALU_DECODE_ILLEGAL_CHK_EN` defined: `illegal_w_o_h` is registered with the bundle and set for any of:
  - an unknown opcode;
  - OP with funct7 ∉ {0000000, 0100000};
  - OP with funct7=0100000 and f3 ∉ {000, 101};
  - a shift-immediate with instr[31:25] ∉ {0000000, 0100000}.

  When set, `alu_control`=0000, flag=0 and `reg_wr_w_o_h`=0.
- Undefined: `illegal_w_o_h` is tied 0, no checking logic is built, and unknown opcodes decode as ADD with `reg_wr_w_o_h`=0.

## Test plan
- `add x3,x1,x2` 0x002081B3, valid, ready → next cycle: `alu_control`=0000, flag=1, `b_sel_imm_w_o_h`=0, rd=3, `reg_wr_w_o_h`=1.
- `sub x3,x1,x2` 0x402081B3 → `alu_control`=1000, flag=1.
- `srai x5,x6,3` 0x40335293 → `alu_control`=1101, imm[4:0]=3, rs1=6. `xori x1,x1,0x400` 0x4000C093 → `alu_control`=0100, flag=0, imm=0x00000400.
- `addi x1,x0,-1` 0xFFF00093, then `out_ready_w_i_h`=0 for 3 cycles → imm=0xFFFFFFFF and the bundle holds. `in_ready_w_o_h`=0 until ready rises, then the next word loads in the same cycle.
- Flush asserted together with a valid input → `out_valid_w_o_h`=0 next cycle. `rst_w_i_l` pulsed low between edges → outputs 0 immediately.
- With `ALU_DECODE_ILLEGAL_CHK_EN`: 0x7E2081B3 → `illegal_w_o_h`=1, `alu_control`=0000, `reg_wr_w_o_h`=0. Without the macro → `illegal_w_o_h`=0.
